vga_apb_pixel_master: RTL and testbench

//   APB initiator that drives the VGA APB pixel-write slave. Accepts pixel requests
//   (x, y, color) over a valid/ready stream and buffers them in a small FIFO. Turns each

---
 rtl/vga_apb_pixel_master.sv | 195 +++++++++++++++++++
 tb/tb_vga_apb_pixel_master.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_apb_pixel_master.sv
// APB initiator for the VGA pixel-write slave: buffers (x, y, color) requests in a
// small FIFO and turns each one into four APB writes (X, Y, COLOR, WE).
//
// state  | meaning
// IDLE   | no transfer; waiting for a buffered pixel
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase; waiting for pready or timeout
module vga_apb_pixel_master #(
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter int                        APB_DATA_WIDTH = 32,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int                        FIFO_DEPTH     = 4,
    parameter int                        TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      pix_valid_i,
    output logic                      pix_ready_o,
    input  logic [10:0]               pix_x_i,
    input  logic [10:0]               pix_y_i,
    input  logic                      pix_color_i,
    output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
    output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
    output logic                      apb_pwrite_o,
    output logic                      apb_psel_o,
    output logic                      apb_penable_o,
    input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
    input  logic                      apb_pready_i,
    input  logic                      apb_pslverr_i,
    output logic                      busy_o,
    output logic                      err_o,
    input  logic                      err_clr_i
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        color;
    } pix_t;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t                    state_q;
    pix_t                      mem_q [FIFO_DEPTH];
    pix_t                      head;
    pix_t                      work_q;
    logic [PW-1:0]             wptr_q, rptr_q;
    logic [CW-1:0]             cnt_q, cnt_nxt;
    logic                      rdy_q;
    logic                      push, pop, empty;
    logic [1:0]                idx_q;
    logic [TW-1:0]             tmo_q;
    logic                      xfer_end, err_set;
    logic                      err_q, psel_q, penable_q, pwrite_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      unused_prdata;

    assign unused_prdata = ^apb_prdata_i;

    function automatic logic [APB_ADDR_WIDTH-1:0] addr_of(input logic [1:0] idx);
        addr_of = BASE_ADDR + APB_ADDR_WIDTH'({idx, 2'b00});
    endfunction

    function automatic logic [APB_DATA_WIDTH-1:0] data_of(input logic [1:0] idx, input pix_t p);
        case (idx)
            2'd0:    data_of = APB_DATA_WIDTH'(p.x);
            2'd1:    data_of = APB_DATA_WIDTH'(p.y);
            2'd2:    data_of = APB_DATA_WIDTH'(p.color);
            default: data_of = APB_DATA_WIDTH'(1);
        endcase
    endfunction

    assign empty = (cnt_q == '0);
    assign push  = pix_valid_i & rdy_q;
    assign head  = mem_q[rptr_q];

    always_comb begin
        cnt_nxt = cnt_q;
        if (push && !pop)
            cnt_nxt = cnt_q + CW'(1);
        else if (pop && !push)
            cnt_nxt = cnt_q - CW'(1);
    end

    // Ready is registered from the next count, so it never depends on a same-cycle pop.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            rdy_q  <= 1'b0;
        end else begin
            if (push)
                wptr_q <= wptr_q + PW'(1);
            if (pop)
                rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_nxt;
            rdy_q <= (cnt_nxt != CW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wptr_q] <= {pix_x_i, pix_y_i, pix_color_i};
    end

    // A pixel ends on its last write, on pslverr, or on timeout; all share one exit path.
    always_comb begin
        xfer_end = 1'b0;
        err_set  = 1'b0;
        if (state_q == S_ACCESS) begin
            if (apb_pready_i) begin
                xfer_end = apb_pslverr_i || (idx_q == 2'd3);
                err_set  = apb_pslverr_i;
            end else begin
                xfer_end = (tmo_q == TW'(1));
                err_set  = (tmo_q == TW'(1));
            end
        end
        pop = !empty && ((state_q == S_IDLE) || xfer_end);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_IDLE;
            work_q    <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            if (err_set)
                err_q <= 1'b1;
            else if (err_clr_i)
                err_q <= 1'b0;

            if (pop) begin
                work_q    <= head;
                idx_q     <= 2'd0;
                tmo_q     <= TW'(TIMEOUT_CYCLES);
                state_q   <= S_SETUP;
                psel_q    <= 1'b1;
                penable_q <= 1'b0;
                pwrite_q  <= 1'b1;
                paddr_q   <= addr_of(2'd0);
                pwdata_q  <= data_of(2'd0, head);
            end else begin
                case (state_q)
                    S_IDLE: ;
                    S_SETUP: begin
                        state_q   <= S_ACCESS;
                        penable_q <= 1'b1;
                    end
                    S_ACCESS: begin
                        if (xfer_end) begin
                            state_q   <= S_IDLE;
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                            pwrite_q  <= 1'b0;
                        end else if (apb_pready_i) begin
                            idx_q     <= idx_q + 2'd1;
                            tmo_q     <= TW'(TIMEOUT_CYCLES);
                            state_q   <= S_SETUP;
                            penable_q <= 1'b0;
                            paddr_q   <= addr_of(idx_q + 2'd1);
                            pwdata_q  <= data_of(idx_q + 2'd1, work_q);
                        end else begin
                            tmo_q <= tmo_q - TW'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign pix_ready_o   = rdy_q;
    assign apb_paddr_o   = paddr_q;
    assign apb_pwdata_o  = pwdata_q;
    assign apb_pwrite_o  = pwrite_q;
    assign apb_psel_o    = psel_q;
    assign apb_penable_o = penable_q;
    assign busy_o        = (state_q != S_IDLE) | ~empty;
    assign err_o         = err_q;

endmodule

// File: tb/tb_vga_apb_pixel_master.sv
// Randomized bench for vga_apb_pixel_master: an APB slave model with configurable wait
// and error plans, and a transaction-level model of the expected write sequence.
module tb_vga_apb_pixel_master;

    localparam int              AW   = 12;
    localparam int              DW   = 32;
    localparam logic [AW-1:0]   BASE = 12'h0;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        c;
    } pix_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          pw;
        logic          err;
    } xfer_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          pix_valid = 1'b0;
    logic          pix_ready_o;
    logic [10:0]   pix_x = '0, pix_y = '0;
    logic          pix_c = 1'b0;
    logic [AW-1:0] apb_paddr_o;
    logic [DW-1:0] apb_pwdata_o;
    logic          apb_pwrite_o, apb_psel_o, apb_penable_o;
    logic          apb_pready_i = 1'b0, apb_pslverr_i = 1'b0;
    logic          busy_o, err_o;
    logic          err_clr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // slave configuration (written by the stimulus process only)
    int         fixed_wait = 1;
    bit         rand_wait  = 1'b0;
    int         max_wait   = 0;
    bit [255:0] err_plan   = '0;

    // slave/monitor state (written by the negedge process only)
    int    wait_cnt = 0, wait_target = 0;
    int    xfer_idx = 0;
    int    psel_hi_cnt = 0, psel_rise_cnt = 0, access_cnt = 0;
    logic  psel_prev = 1'b0;
    xfer_t log_q[$];

    pix_t  pix_q[$];
    xfer_t exp_q[$];

    always #5 clk = ~clk;

    vga_apb_pixel_master #(
        .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .BASE_ADDR(BASE),
        .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rstn_i(rstn),
        .pix_valid_i(pix_valid), .pix_ready_o(pix_ready_o),
        .pix_x_i(pix_x), .pix_y_i(pix_y), .pix_color_i(pix_c),
        .apb_paddr_o(apb_paddr_o), .apb_pwdata_o(apb_pwdata_o),
        .apb_pwrite_o(apb_pwrite_o), .apb_psel_o(apb_psel_o),
        .apb_penable_o(apb_penable_o), .apb_prdata_i('0),
        .apb_pready_i(apb_pready_i), .apb_pslverr_i(apb_pslverr_i),
        .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr)
    );

    // APB slave model and activity monitor; drives responses away from the active edge.
    always @(negedge clk) begin
        xfer_t e;
        if (apb_psel_o) psel_hi_cnt++;
        if (apb_psel_o && !psel_prev) psel_rise_cnt++;
        psel_prev = apb_psel_o;
        if (apb_psel_o && apb_penable_o) begin
            access_cnt++;
            if (wait_cnt >= wait_target) begin
                apb_pready_i  = 1'b1;
                apb_pslverr_i = err_plan[xfer_idx % 256];
                e = {apb_paddr_o, apb_pwdata_o, apb_pwrite_o, err_plan[xfer_idx % 256]};
                log_q.push_back(e);
                xfer_idx++;
            end else begin
                apb_pready_i  = 1'b0;
                apb_pslverr_i = 1'b0;
            end
            wait_cnt++;
        end else begin
            apb_pready_i  = 1'b0;
            apb_pslverr_i = 1'b0;
            wait_cnt      = 0;
            wait_target   = rand_wait ? int'($urandom_range(max_wait, 0)) : fixed_wait;
        end
    end

    // Expected write stream: 4 writes per pixel, truncated after a write the slave errors.
    function automatic void build_exp(input int t0);
        int t;
        t = t0;
        exp_q.delete();
        foreach (pix_q[p]) begin
            for (int k = 0; k < 4; k++) begin
                xfer_t e;
                e.addr = BASE + AW'(4 * k);
                case (k)
                    0:       e.data = DW'(pix_q[p].x);
                    1:       e.data = DW'(pix_q[p].y);
                    2:       e.data = DW'(pix_q[p].c);
                    default: e.data = DW'(1);
                endcase
                e.pw  = 1'b1;
                e.err = err_plan[t % 256];
                t++;
                exp_q.push_back(e);
                if (e.err) break;
            end
        end
    endfunction

    task automatic push_pixel(input logic [10:0] x, input logic [10:0] y, input logic c);
        int n;
        pix_x = x; pix_y = y; pix_c = c; pix_valid = 1'b1;
        n = 0;
        while (!pix_ready_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!pix_ready_o) begin
            n_fail++;
            $display("FAIL push_accept: pix_ready_o=%0b after %0d cycles, required 1", pix_ready_o, n);
        end else begin
            pix_q.push_back(pix_t'({x, y, c}));
        end
        @(posedge clk);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((busy_o || apb_psel_o) && n < bound) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (busy_o || apb_psel_o) begin
            n_fail++;
            $display("FAIL wait_idle: busy_o=%0b psel=%0b after %0d cycles, required 0", busy_o, apb_psel_o, n);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pix_ready_o, apb_psel_o, apb_penable_o, apb_pwrite_o, busy_o, err_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: {rdy,psel,pen,pwr,busy,err}=%b, required 000000",
                     {pix_ready_o, apb_psel_o, apb_penable_o, apb_pwrite_o, busy_o, err_o});
        end
        n_checks++;
        if (apb_paddr_o !== '0 || apb_pwdata_o !== '0) begin
            n_fail++;
            $display("FAIL reset_bus: paddr=%h pwdata=%h, required 0", apb_paddr_o, apb_pwdata_o);
        end
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pix_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b busy=%b, required 1/0", pix_ready_o, busy_o);
        end
    endtask

    task automatic test_single();
        int lb, t0, h0;
        fixed_wait = 1; rand_wait = 1'b0; err_plan = '0;
        pix_q.delete();
        lb = log_q.size(); t0 = xfer_idx; h0 = psel_hi_cnt;
        push_pixel(11'd5, 11'd7, 1'b1);
        n_checks++;
        if (apb_psel_o !== 1'b0) begin
            n_fail++;
            $display("FAIL single_lat_n1: psel=%b, required 0", apb_psel_o);
        end
        @(negedge clk);
        n_checks++;
        if (apb_psel_o !== 1'b1 || apb_penable_o !== 1'b0 || apb_paddr_o !== BASE) begin
            n_fail++;
            $display("FAIL single_lat_n2: psel=%b pen=%b paddr=%h, required 1/0/%h",
                     apb_psel_o, apb_penable_o, apb_paddr_o, BASE);
        end
        wait_idle(200);
        n_checks++;
        if (psel_hi_cnt - h0 !== 12) begin
            n_fail++;
            $display("FAIL single_cycles: %0d psel cycles, required 12", psel_hi_cnt - h0);
        end
        build_exp(t0);
        n_checks++;
        if (log_q.size() - lb !== exp_q.size()) begin
            n_fail++;
            $display("FAIL single_count: %0d writes, required %0d", log_q.size() - lb, exp_q.size());
        end
        foreach (exp_q[i]) if (lb + i < log_q.size()) begin
            n_checks++;
            if (log_q[lb + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL single_write%0d: got %h, required %h", i, log_q[lb + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        int lb, t0;
        fixed_wait = 3; rand_wait = 1'b0; err_plan = '0;
        pix_q.delete();
        lb = log_q.size(); t0 = xfer_idx;
        for (int i = 0; i < 5; i++)
            push_pixel(11'($urandom), 11'($urandom), 1'($urandom));
        n_checks++;
        if (pix_ready_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_full: ready=%b busy=%b, required 0/1", pix_ready_o, busy_o);
        end
        push_pixel(11'($urandom), 11'($urandom), 1'($urandom));
        wait_idle(2000);
        build_exp(t0);
        n_checks++;
        if (log_q.size() - lb !== exp_q.size()) begin
            n_fail++;
            $display("FAIL stall_count: %0d writes, required %0d", log_q.size() - lb, exp_q.size());
        end
        foreach (exp_q[i]) if (lb + i < log_q.size()) begin
            n_checks++;
            if (log_q[lb + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL stall_write%0d: got %h, required %h", i, log_q[lb + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lb, t0, h0, r0;
        fixed_wait = 0; rand_wait = 1'b0; err_plan = '0;
        pix_q.delete();
        lb = log_q.size(); t0 = xfer_idx; h0 = psel_hi_cnt; r0 = psel_rise_cnt;
        for (int i = 0; i < 3; i++)
            push_pixel(11'($urandom), 11'($urandom), 1'($urandom));
        wait_idle(500);
        n_checks++;
        if (psel_hi_cnt - h0 !== 24 || psel_rise_cnt - r0 !== 1) begin
            n_fail++;
            $display("FAIL b2b_timing: %0d psel cycles %0d rises, required 24 and 1",
                     psel_hi_cnt - h0, psel_rise_cnt - r0);
        end
        build_exp(t0);
        n_checks++;
        if (log_q.size() - lb !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: %0d writes, required %0d", log_q.size() - lb, exp_q.size());
        end
        foreach (exp_q[i]) if (lb + i < log_q.size()) begin
            n_checks++;
            if (log_q[lb + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_write%0d: got %h, required %h", i, log_q[lb + i], exp_q[i]);
            end
        end
    endtask

    task automatic test_slverr();
        int lb, t0;
        fixed_wait = 1; rand_wait = 1'b0; err_plan = '0;
        pix_q.delete();
        lb = log_q.size(); t0 = xfer_idx;
        err_plan[(t0 + 1) % 256] = 1'b1;
        push_pixel(11'($urandom), 11'($urandom), 1'($urandom));
        push_pixel(11'($urandom), 11'($urandom), 1'($urandom));
        wait_idle(500);
        n_checks++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL slverr_flag: err_o=%b, required 1", err_o);
        end
        build_exp(t0);
        n_checks++;
        if (log_q.size() - lb !== exp_q.size()) begin
            n_fail++;
            $display("FAIL slverr_count: %0d writes, required %0d", log_q.size() - lb, exp_q.size());
        end
        foreach (exp_q[i]) if (lb + i < log_q.size()) begin
            n_checks++;
            if (log_q[lb + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL slverr_write%0d: got %h, required %h", i, log_q[lb + i], exp_q[i]);
            end
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL slverr_clear: err_o=%b, required 0", err_o);
        end
    endtask

    task automatic test_timeout();
        int lb, a0;
        fixed_wait = 100000; rand_wait = 1'b0; err_plan = '0;
        pix_q.delete();
        lb = log_q.size(); a0 = access_cnt;
        push_pixel(11'($urandom), 11'($urandom), 1'($urandom));
        wait_idle(300);
        n_checks++;
        if (access_cnt - a0 !== 16) begin
            n_fail++;
            $display("FAIL timeout_cycles: %0d access cycles, required 16", access_cnt - a0);
        end
        n_checks++;
        if (err_o !== 1'b1 || apb_psel_o !== 1'b0 || log_q.size() !== lb) begin
            n_fail++;
            $display("FAIL timeout_state: err=%b psel=%b writes=%0d, required 1/0/0",
                     err_o, apb_psel_o, log_q.size() - lb);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_random();
        int lb, t0;
        logic any_err;
        fixed_wait = 0; rand_wait = 1'b1; max_wait = 3;
        pix_q.delete();
        lb = log_q.size(); t0 = xfer_idx;
        for (int i = 0; i < 256; i++) err_plan[i] = ($urandom_range(7, 0) == 0);
        for (int i = 0; i < 20; i++) begin
            push_pixel(11'($urandom), 11'($urandom), 1'($urandom));
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end
        wait_idle(3000);
        build_exp(t0);
        any_err = 1'b0;
        foreach (exp_q[i]) any_err |= exp_q[i].err;
        n_checks++;
        if (log_q.size() - lb !== exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: %0d writes, required %0d", log_q.size() - lb, exp_q.size());
        end
        foreach (exp_q[i]) if (lb + i < log_q.size()) begin
            n_checks++;
            if (log_q[lb + i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_write%0d: got %h, required %h", i, log_q[lb + i], exp_q[i]);
            end
        end
        n_checks++;
        if (err_o !== any_err) begin
            n_fail++;
            $display("FAIL rand_err: err_o=%b, required %b", err_o, any_err);
        end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        rand_wait = 1'b0;
        err_plan = '0;
    endtask

    task automatic test_reset_mid();
        int n, r0;
        fixed_wait = 100000; rand_wait = 1'b0; err_plan = '0;
        pix_q.delete();
        for (int i = 0; i < 3; i++)
            push_pixel(11'($urandom), 11'($urandom), 1'($urandom));
        n = 0;
        while (!(apb_psel_o && apb_penable_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!(apb_psel_o && apb_penable_o)) begin
            n_fail++;
            $display("FAIL rstmid_access: psel=%b pen=%b, required 1/1", apb_psel_o, apb_penable_o);
        end
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({apb_psel_o, apb_penable_o, busy_o, pix_ready_o} !== 4'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: {psel,pen,busy,rdy}=%b, required 0000",
                     {apb_psel_o, apb_penable_o, busy_o, pix_ready_o});
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (pix_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_release: ready=%b busy=%b, required 1/0", pix_ready_o, busy_o);
        end
        r0 = psel_rise_cnt;
        repeat (5) @(negedge clk);
        n_checks++;
        if (psel_rise_cnt !== r0 || apb_psel_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_fifo_empty: rises=%0d psel=%b busy=%b, required 0/0/0",
                     psel_rise_cnt - r0, apb_psel_o, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_slverr();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
